rsa_operand_sequencer: RTL and testbench

- Sits between the UART word assembler (serial_to_parallel, N-bit words with a one-cycle valid) and the word serializer (parallel_to_serial) in the RSA UART datapath.
- Collects three consecutive words (base, exponent, modulus), launches the modular-exponentiation core, waits for its result, then hands the result word downstream once the UART transmitter is idle.
- Adds overrun detection and an optional core-hang timeout.

---
 rtl/rsa_operand_sequencer.sv | 121 ++++++++++++
 tb/tb_rsa_operand_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_operand_sequencer.sv
// Operand sequencer for the RSA UART datapath: gathers base/exp/mod words, runs the core, forwards the result.
// Optional core-hang abort is compiled in with `define RSA_SEQ_TIMEOUT_EN.
module rsa_operand_sequencer #(
    parameter int N              = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [N-1:0] rx_bytes,
    output logic [N-1:0] core_base,
    output logic [N-1:0] core_exp,
    output logic [N-1:0] core_mod,
    output logic         core_start,
    input  logic         core_done,
    input  logic [N-1:0] core_result,
    input  logic         tx_busy,
    output logic         tx_valid,
    output logic [N-1:0] tx_bytes,
    output logic         busy,
    output logic         overrun,
    output logic         timeout
);

    typedef enum logic [2:0] {
        LOAD_BASE,
        LOAD_EXP,
        LOAD_MOD,
        START,
        WAIT_CORE,
        SEND
    } state_t;

    state_t state, state_nxt;
    logic   abort;
    logic   mod_zero;

    assign mod_zero = (rx_bytes == '0);

`ifdef RSA_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    // wait_cnt is 0 in the first WAIT_CORE cycle, so the abort lands on the TIMEOUT_CYCLES-th one
    assign abort = (state == WAIT_CORE) && !core_done && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT_CORE) ? wait_cnt + 1'b1 : '0;
            if (abort)
                timeout <= 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= LOAD_BASE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD_BASE: if (rx_valid) state_nxt = LOAD_EXP;
            LOAD_EXP:  if (rx_valid) state_nxt = LOAD_MOD;
            LOAD_MOD:  if (rx_valid) state_nxt = mod_zero ? SEND : START;
            START:     state_nxt = WAIT_CORE;
            WAIT_CORE: if (core_done || abort) state_nxt = SEND;
            SEND:      if (!tx_busy) state_nxt = LOAD_BASE;
            default:   state_nxt = LOAD_BASE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_base  <= '0;
            core_exp   <= '0;
            core_mod   <= '0;
            core_start <= 1'b0;
            tx_valid   <= 1'b0;
            tx_bytes   <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            core_start <= (state == LOAD_MOD) && rx_valid && !mod_zero;
            tx_valid   <= (state == SEND) && !tx_busy;
            busy       <= (state_nxt != LOAD_BASE);

            if (rx_valid) begin
                case (state)
                    LOAD_BASE: core_base <= rx_bytes;
                    LOAD_EXP:  core_exp  <= rx_bytes;
                    LOAD_MOD: begin
                        core_mod <= rx_bytes;
                        // a zero modulus has no defined result; answer all-ones without starting the core
                        if (mod_zero)
                            tx_bytes <= '1;
                    end
                    default:   overrun <= 1'b1;
                endcase
            end

            if (state == WAIT_CORE) begin
                if (core_done)
                    tx_bytes <= core_result;
                else if (abort)
                    tx_bytes <= '1;
            end
        end
    end

endmodule

// File: tb/tb_rsa_operand_sequencer.sv
// Directed bench for rsa_operand_sequencer: transaction-level reference model compared every cycle plus literal checks.
module tb_rsa_operand_sequencer;

    localparam int N  = 32;
    localparam int TO = 100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rx_valid;
    logic [N-1:0] rx_bytes;
    logic [N-1:0] core_base, core_exp, core_mod;
    logic         core_start;
    logic         core_done;
    logic [N-1:0] core_result;
    logic         tx_busy;
    logic         tx_valid;
    logic [N-1:0] tx_bytes;
    logic         busy, overrun, timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    rsa_operand_sequencer #(.N(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_bytes(rx_bytes),
        .core_base(core_base), .core_exp(core_exp), .core_mod(core_mod),
        .core_start(core_start), .core_done(core_done), .core_result(core_result),
        .tx_busy(tx_busy), .tx_valid(tx_valid), .tx_bytes(tx_bytes),
        .busy(busy), .overrun(overrun), .timeout(timeout)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send3(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
        rx_valid = 1'b1; rx_bytes = a; tick;
        rx_bytes = b; tick;
        rx_bytes = c; tick;
        rx_valid = 1'b0; rx_bytes = '0;
    endtask

    // Reference model: words collected so far, whether a core job is launching/running, whether a reply is owed.
    int           nw = 0;
    int           ph = 0;  // 0 none, 1 launch cycle, 2 core running
    bit           pend = 0;
    logic [N-1:0] m_base = '0, m_exp = '0, m_mod = '0, m_tx = '0;
    bit           m_start = 0, m_txv = 0, m_busy = 0, m_ovr = 0, m_to = 0;
`ifdef RSA_SEQ_TIMEOUT_EN
    int           wcnt = 0;
`endif

    always @(posedge clk) begin
        if (!rst_n) begin
            nw = 0; ph = 0; pend = 0;
            m_base = '0; m_exp = '0; m_mod = '0; m_tx = '0;
            m_start = 0; m_txv = 0; m_busy = 0; m_ovr = 0; m_to = 0;
        end else begin
            m_start = 0;
            m_txv   = 0;
            if (pend) begin
                if (rx_valid) m_ovr = 1;
                if (!tx_busy) begin m_txv = 1; pend = 0; end
            end else if (ph == 1) begin
                if (rx_valid) m_ovr = 1;
                ph = 2;
`ifdef RSA_SEQ_TIMEOUT_EN
                wcnt = 0;
`endif
            end else if (ph == 2) begin
                if (rx_valid) m_ovr = 1;
`ifdef RSA_SEQ_TIMEOUT_EN
                wcnt++;
`endif
                if (core_done) begin
                    m_tx = core_result; pend = 1; ph = 0;
                end
`ifdef RSA_SEQ_TIMEOUT_EN
                else if (wcnt == TO) begin
                    m_tx = '1; m_to = 1; pend = 1; ph = 0;
                end
`endif
            end else if (rx_valid) begin
                if (nw == 0) begin
                    m_base = rx_bytes; nw = 1;
                end else if (nw == 1) begin
                    m_exp = rx_bytes; nw = 2;
                end else begin
                    m_mod = rx_bytes; nw = 0;
                    if (rx_bytes == '0) begin m_tx = '1; pend = 1; end
                    else begin m_start = 1; ph = 1; end
                end
            end
            m_busy = pend || (ph != 0) || (nw != 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_core_base",  core_base,  m_base);
            chk("cyc_core_exp",   core_exp,   m_exp);
            chk("cyc_core_mod",   core_mod,   m_mod);
            chk("cyc_core_start", core_start, m_start);
            chk("cyc_tx_valid",   tx_valid,   m_txv);
            chk("cyc_tx_bytes",   tx_bytes,   m_tx);
            chk("cyc_busy",       busy,       m_busy);
            chk("cyc_overrun",    overrun,    m_ovr);
            chk("cyc_timeout",    timeout,    m_to);
            if (core_start === 1'b1) n_start++;
        end
    end

    initial begin
        int ns;
        rst_n = 1'b0; rx_valid = 1'b0; rx_bytes = '0;
        core_done = 1'b0; core_result = '0; tx_busy = 1'b0;
        tick; tick;
        chk_en = 1'b1;
        chk("rst_core_base", core_base, 0);
        chk("rst_tx_bytes", tx_bytes, 0);
        chk("rst_outputs", {core_start, tx_valid, busy, overrun, timeout}, 0);
        rst_n = 1'b1;
        tick;

        // basic run
        ns = n_start;
        send3(4, 13, 497);
        chk("basic_start", core_start, 1);
        chk("basic_base", core_base, 4);
        chk("basic_exp", core_exp, 13);
        chk("basic_mod", core_mod, 497);
        tick;
        chk("basic_start_one_cycle", core_start, 0);
        repeat (18) tick;
        core_done = 1'b1; core_result = 445; tick;
        core_done = 1'b0;
        chk("basic_tx_not_early", tx_valid, 0);
        tick;
        chk("basic_tx_valid", tx_valid, 1);
        chk("basic_tx_bytes", tx_bytes, 445);
        chk("basic_busy_idle", busy, 0);
        tick;
        chk("basic_tx_pulse", tx_valid, 0);
        chk("basic_overrun", overrun, 0);
        chk("basic_start_count", n_start, ns + 1);

        // back-pressure
        send3(2, 5, 11);
        tx_busy = 1'b1;
        repeat (6) tick;
        core_done = 1'b1; core_result = 32'h1234; tick;
        core_done = 1'b0;
        repeat (50) begin
            chk("bp_hold_valid", tx_valid, 0);
            chk("bp_hold_bytes", tx_bytes, 32'h1234);
            tick;
        end
        tx_busy = 1'b0;
        tick;
        chk("bp_tx_valid", tx_valid, 1);
        chk("bp_tx_bytes", tx_bytes, 32'h1234);
        tick;
        chk("bp_tx_pulse", tx_valid, 0);

        // zero modulus
        ns = n_start;
        send3(7, 3, 0);
        chk("zm_no_start", core_start, 0);
        chk("zm_mod", core_mod, 0);
        chk("zm_tx_bytes", tx_bytes, 32'hFFFF_FFFF);
        tick;
        chk("zm_tx_valid", tx_valid, 1);
        tick;
        chk("zm_start_count", n_start, ns);

        // overrun during WAIT_CORE
        send3(9, 8, 21);
        tick; tick;
        rx_valid = 1'b1; rx_bytes = 99; tick;
        rx_valid = 1'b0;
        chk("ovr_flag", overrun, 1);
        chk("ovr_base", core_base, 9);
        chk("ovr_exp", core_exp, 8);
        chk("ovr_mod", core_mod, 21);
        repeat (3) tick;
        core_done = 1'b1; core_result = 5; tick;
        core_done = 1'b0; tick;
        chk("ovr_tx_valid", tx_valid, 1);
        chk("ovr_tx_bytes", tx_bytes, 5);
        send3(1, 2, 3);
        chk("ovr_next_base", core_base, 1);
        chk("ovr_next_exp", core_exp, 2);
        chk("ovr_next_mod", core_mod, 3);
        chk("ovr_next_start", core_start, 1);
        repeat (3) tick;
        // word on the SEND cycle is dropped, the one right after is the new base
        core_done = 1'b1; core_result = 6; tick;
        core_done = 1'b0;
        rx_valid = 1'b1; rx_bytes = 50; tick;
        chk("send_tx_valid", tx_valid, 1);
        chk("send_tx_bytes", tx_bytes, 6);
        rx_bytes = 60; tick;
        rx_valid = 1'b0;
        chk("send_next_base", core_base, 60);
        chk("send_busy", busy, 1);
        rx_valid = 1'b1; rx_bytes = 61; tick;
        rx_bytes = 0; tick;
        rx_valid = 1'b0; tick;
        chk("send_zm_tx_valid", tx_valid, 1);
        chk("send_zm_exp", core_exp, 61);
        tick;

        // reset mid-operation
        send3(3, 4, 5);
        repeat (5) tick;
        rst_n = 1'b0; tick;
        rst_n = 1'b1;
        chk("mrst_operands", {core_base, core_exp, core_mod}, 0);
        chk("mrst_tx_bytes", tx_bytes, 0);
        chk("mrst_flags", {core_start, tx_valid, busy, overrun, timeout}, 0);
        core_done = 1'b1; core_result = 9; tick;
        core_done = 1'b0;
        repeat (5) begin
            chk("mrst_no_tx", tx_valid, 0);
            chk("mrst_idle", busy, 0);
            tick;
        end

`ifdef RSA_SEQ_TIMEOUT_EN
        send3(1, 1, 7);
        repeat (TO) tick;
        chk("to_not_yet", timeout, 0);
        tick;
        chk("to_flag", timeout, 1);
        chk("to_tx_bytes", tx_bytes, 32'hFFFF_FFFF);
        tick;
        chk("to_tx_valid", tx_valid, 1);
        rst_n = 1'b0; tick;
        rst_n = 1'b1;
        send3(1, 1, 7);
        repeat (TO) tick;
        core_done = 1'b1; core_result = 77; tick;
        core_done = 1'b0;
        chk("to_race_flag", timeout, 0);
        chk("to_race_bytes", tx_bytes, 77);
        tick;
        chk("to_race_tx_valid", tx_valid, 1);
        tick;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
